axis_route_ctrl_2x2: RTL and testbench



---
 rtl/axis_route_pkg.sv | 34 +++
 rtl/axis_pkt_tracker.sv | 59 +++++
 rtl/axis_route_ctrl_2x2.sv | 124 ++++++++++++
 tb/tb_axis_route_ctrl_2x2.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_route_pkg.sv
// Shared types for the 2x2 AXI-Stream route controller: route encoding,
// packet-tracker states and the route-to-enable decode.
package axis_route_pkg;

  typedef enum logic [1:0] {
    ROUTE_S0_M0 = 2'd0,
    ROUTE_S1_M0 = 2'd1,
    ROUTE_S0_M1 = 2'd2,
    ROUTE_S1_M1 = 2'd3
  } route_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } fsm_t;

  typedef struct packed {
    logic m0;
    logic m1;
    logic s0;
    logic s1;
  } route_en_t;

  // Bit 1 selects the master, bit 0 selects the slave.
  function automatic route_en_t route_decode(input route_t r);
    route_en_t en;
    en.m0 = ~r[1];
    en.m1 = r[1];
    en.s0 = ~r[0];
    en.s1 = r[0];
    return en;
  endfunction

endpackage

// File: rtl/axis_pkt_tracker.sv
// Packet framing tracker for the active switch path: IDLE/IN_PKT state,
// beat and packet counters, and the switch-safe flag.
module axis_pkt_tracker
  import axis_route_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_act_v,
  input  logic            i_act_r,
  input  logic            i_act_l,
  input  logic            i_apply,
  output fsm_t            o_state,
  output logic [CNTW-1:0] o_beat_cnt,
  output logic [CNTW-1:0] o_pkt_cnt,
  output logic            o_safe
);

  localparam logic [CNTW-1:0] CNT_ONE = 1;

  fsm_t            r_state;
  logic [CNTW-1:0] r_beat_cnt;
  logic [CNTW-1:0] r_pkt_cnt;
  logic            w_beat;
  logic            w_last_beat;

  assign w_beat      = i_act_v & i_act_r;
  assign w_last_beat = w_beat & i_act_l;

  // An offered-but-unaccepted beat must not be withdrawn, so it blocks the switch.
  assign o_safe = ((r_state == IDLE) && !(i_act_v && !i_act_r)) || w_last_beat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_last_beat)
        r_pkt_cnt <= r_pkt_cnt + CNT_ONE;

      if (i_apply || w_last_beat)
        r_beat_cnt <= '0;
      else if (w_beat)
        r_beat_cnt <= r_beat_cnt + CNT_ONE;

      if (i_apply)
        r_state <= IDLE;
      else if (w_beat)
        r_state <= i_act_l ? IDLE : IN_PKT;
    end
  end

  assign o_state    = r_state;
  assign o_beat_cnt = r_beat_cnt;
  assign o_pkt_cnt  = r_pkt_cnt;

endmodule

// File: rtl/axis_route_ctrl_2x2.sv
// Route controller for the 2x2 AXI-Stream switch: applies route requests at
// packet boundaries. Optional forced switch on stall: AXIS_ROUTE_TIMEOUT_EN.
module axis_route_ctrl_2x2
  import axis_route_pkg::*;
#(
  parameter logic [1:0] DEFAULT_ROUTE  = 2'd0,
  parameter int         CNTW           = 16,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [1:0]      req_route,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            s0_tvalid,
  input  logic            s0_tready,
  input  logic            s0_tlast,
  input  logic            s1_tvalid,
  input  logic            s1_tready,
  input  logic            s1_tlast,
  output logic            m0_en,
  output logic            m1_en,
  output logic            s0_en,
  output logic            s1_en,
  output logic [1:0]      cur_route,
  output logic            in_pkt,
  output logic [CNTW-1:0] pkt_cnt,
  output logic [CNTW-1:0] beat_cnt,
  output logic            timeout_evt
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  route_t    r_route;
  route_en_t r_en;
  logic      r_pend;
  route_t    r_pend_route;
  fsm_t      w_state;
  logic      w_act_v;
  logic      w_act_r;
  logic      w_act_l;
  logic      w_safe;
  logic      w_force;
  logic      w_apply;

  assign w_act_v = r_route[0] ? s1_tvalid : s0_tvalid;
  assign w_act_r = r_route[0] ? s1_tready : s0_tready;
  assign w_act_l = r_route[0] ? s1_tlast  : s0_tlast;

  axis_pkt_tracker #(.CNTW(CNTW)) u_tracker (
    .i_clk      (aclk),
    .i_rst_n    (aresetn),
    .i_act_v    (w_act_v),
    .i_act_r    (w_act_r),
    .i_act_l    (w_act_l),
    .i_apply    (w_apply),
    .o_state    (w_state),
    .o_beat_cnt (beat_cnt),
    .o_pkt_cnt  (pkt_cnt),
    .o_safe     (w_safe)
  );

`ifdef AXIS_ROUTE_TIMEOUT_EN
  localparam int            STW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [STW-1:0] STALL_LIM = STW'(TIMEOUT_CYCLES - 1);
  localparam logic [STW-1:0] STALL_ONE = 1;

  logic [STW-1:0] r_stall;
  logic           r_tevt;
  logic           w_beat;

  assign w_beat  = w_act_v & w_act_r;
  assign w_force = r_pend && !w_safe && (r_stall == STALL_LIM);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stall <= '0;
      r_tevt  <= 1'b0;
    end else begin
      r_tevt <= w_force;
      if (w_apply || w_beat)
        r_stall <= '0;
      else if (r_pend && !w_safe)
        r_stall <= r_stall + STALL_ONE;
    end
  end

  assign timeout_evt = r_tevt;
`else
  assign w_force     = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  // Only an already-pending request can apply, so a request captured on a
  // tlast edge waits for the next safe cycle.
  assign w_apply = r_pend && (w_safe || w_force);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_route      <= route_t'(DEFAULT_ROUTE);
      r_en         <= route_decode(route_t'(DEFAULT_ROUTE));
      r_pend       <= 1'b0;
      r_pend_route <= route_t'(DEFAULT_ROUTE);
    end else if (w_apply) begin
      r_route <= r_pend_route;
      r_en    <= route_decode(r_pend_route);
      r_pend  <= 1'b0;
    end else if (req_valid && !r_pend) begin
      r_pend       <= 1'b1;
      r_pend_route <= route_t'(req_route);
    end
  end

  assign req_ready = ~r_pend;
  assign cur_route = r_route;
  assign m0_en     = r_en.m0;
  assign m1_en     = r_en.m1;
  assign s0_en     = r_en.s0;
  assign s1_en     = r_en.s1;
  assign in_pkt    = (w_state == IN_PKT);

endmodule

// File: tb/tb_axis_route_ctrl_2x2.sv
// Directed bench for axis_route_ctrl_2x2 (DEFAULT_ROUTE=2, CNTW=4, TIMEOUT_CYCLES=8).
module tb_axis_route_ctrl_2x2;

  localparam int CNTW = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [1:0]      req_route;
  logic            req_valid;
  logic            req_ready;
  logic            s0_tvalid, s0_tready, s0_tlast;
  logic            s1_tvalid, s1_tready, s1_tlast;
  logic            m0_en, m1_en, s0_en, s1_en;
  logic [1:0]      cur_route;
  logic            in_pkt;
  logic [CNTW-1:0] pkt_cnt;
  logic [CNTW-1:0] beat_cnt;
  logic            timeout_evt;

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axis_route_ctrl_2x2 #(
    .DEFAULT_ROUTE  (2'd2),
    .CNTW           (CNTW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_route   (req_route),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .s0_tvalid   (s0_tvalid),
    .s0_tready   (s0_tready),
    .s0_tlast    (s0_tlast),
    .s1_tvalid   (s1_tvalid),
    .s1_tready   (s1_tready),
    .s1_tlast    (s1_tlast),
    .m0_en       (m0_en),
    .m1_en       (m1_en),
    .s0_en       (s0_en),
    .s1_en       (s1_en),
    .cur_route   (cur_route),
    .in_pkt      (in_pkt),
    .pkt_cnt     (pkt_cnt),
    .beat_cnt    (beat_cnt),
    .timeout_evt (timeout_evt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_en(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, m0_en, m1_en, s0_en, s1_en}, {28'd0, exp});
  endtask

  initial begin
    aresetn   = 1'b0;
    req_route = 2'd0;
    req_valid = 1'b0;
    {s0_tvalid, s0_tready, s0_tlast} = 3'b000;
    {s1_tvalid, s1_tready, s1_tlast} = 3'b000;

    // Reset values with DEFAULT_ROUTE = 2 (s0->m1)
    repeat (2) tick();
    chk("rst_route", 32'(cur_route), 32'd2);
    chk_en("rst_en", 4'b0110);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_in_pkt", 32'(in_pkt), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_tevt", 32'(timeout_evt), 32'd0);
    aresetn = 1'b1;
    tick();

    // Idle request to route 1: capture edge, then apply edge
    req_route = 2'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("idle_req_ready_low", 32'(req_ready), 32'd0);
    chk("idle_route_hold", 32'(cur_route), 32'd2);
    tick();
    chk("idle_req_ready_back", 32'(req_ready), 32'd1);
    chk("idle_route_1", 32'(cur_route), 32'd1);
    chk_en("idle_en_r1", 4'b1001);

    req_route = 2'd0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("route_0", 32'(cur_route), 32'd0);
    chk_en("en_r0", 4'b1010);

    // 5-beat packet on s0 with a request to route 3 at beat 2
    s0_tvalid = 1'b1;
    s0_tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin
        req_route = 2'd3;
        req_valid = 1'b1;
      end
      s0_tlast = (i == 5);
      tick();
      req_valid = 1'b0;
      if (i == 2) chk("pkt_req_ready_low", 32'(req_ready), 32'd0);
      if (i < 5) begin
        chk("pkt_route_hold", 32'(cur_route), 32'd0);
        chk("pkt_beat_cnt", 32'(beat_cnt), 32'(i));
        chk("pkt_in_pkt", 32'(in_pkt), 32'd1);
      end
    end
    {s0_tvalid, s0_tready, s0_tlast} = 3'b000;
    chk("pkt_route_3", 32'(cur_route), 32'd3);
    chk_en("pkt_en_r3", 4'b0101);
    chk("pkt_cnt_1", 32'(pkt_cnt), 32'd1);
    chk("pkt_beat_clr", 32'(beat_cnt), 32'd0);
    chk("pkt_in_pkt_clr", 32'(in_pkt), 32'd0);
    chk("pkt_req_ready", 32'(req_ready), 32'd1);

    // Route 3: s1 offers a stalled tlast beat; s0 (inactive) chatters
    {s1_tvalid, s1_tready, s1_tlast} = 3'b101;
    {s0_tvalid, s0_tready, s0_tlast} = 3'b111;
    req_route = 2'd0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("stall_req_ready_low", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_route_hold", 32'(cur_route), 32'd3);
      chk("stall_pkt_hold", 32'(pkt_cnt), 32'd1);
      tick();
    end
    s1_tready = 1'b1;
    tick();
    {s1_tvalid, s1_tready, s1_tlast} = 3'b000;
    {s0_tvalid, s0_tready, s0_tlast} = 3'b000;
    chk("stall_route_0", 32'(cur_route), 32'd0);
    chk_en("stall_en_r0", 4'b1010);
    chk("stall_pkt_2", 32'(pkt_cnt), 32'd2);
    chk("stall_req_ready", 32'(req_ready), 32'd1);

    // Reset asserted mid-packet returns everything to reset values
    {s0_tvalid, s0_tready, s0_tlast} = 3'b110;
    tick();
    tick();
    s0_tvalid = 1'b0;
    chk("mid_in_pkt", 32'(in_pkt), 32'd1);
    chk("mid_beat_2", 32'(beat_cnt), 32'd2);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_route", 32'(cur_route), 32'd2);
    chk_en("mid_rst_en", 4'b0110);
    chk("mid_rst_in_pkt", 32'(in_pkt), 32'd0);
    chk("mid_rst_beat", 32'(beat_cnt), 32'd0);
    chk("mid_rst_pkt", 32'(pkt_cnt), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // 17 single-beat packets on s0 wrap the 4-bit packet counter to 1
    {s0_tvalid, s0_tready, s0_tlast} = 3'b111;
    repeat (17) tick();
    {s0_tvalid, s0_tready, s0_tlast} = 3'b000;
    chk("wrap_pkt_1", 32'(pkt_cnt), 32'd1);
    chk("wrap_beat_0", 32'(beat_cnt), 32'd0);
    chk("wrap_in_pkt", 32'(in_pkt), 32'd0);
    chk("wrap_route", 32'(cur_route), 32'd2);
    chk("wrap_req_ready", 32'(req_ready), 32'd1);

    // 17-beat packet: beat counter wraps after 16 beats
    {s0_tvalid, s0_tready, s0_tlast} = 3'b110;
    repeat (16) tick();
    chk("bwrap_beat_0", 32'(beat_cnt), 32'd0);
    chk("bwrap_in_pkt", 32'(in_pkt), 32'd1);
    s0_tlast = 1'b1;
    tick();
    {s0_tvalid, s0_tready, s0_tlast} = 3'b000;
    chk("bwrap_pkt_2", 32'(pkt_cnt), 32'd2);
    chk("bwrap_beat_clr", 32'(beat_cnt), 32'd0);
    chk("bwrap_in_pkt_clr", 32'(in_pkt), 32'd0);

    // Packet stalled mid-stream with a request pending
    {s0_tvalid, s0_tready, s0_tlast} = 3'b110;
    req_route = 2'd1;
    req_valid = 1'b1;
    tick();
    s0_tvalid = 1'b0;
    req_valid = 1'b0;
    chk("to_in_pkt", 32'(in_pkt), 32'd1);
    chk("to_req_ready_low", 32'(req_ready), 32'd0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("to_no_evt_yet", 32'(timeout_evt), 32'd0);
      chk("to_route_hold", 32'(cur_route), 32'd2);
    end
    tick();
`ifdef AXIS_ROUTE_TIMEOUT_EN
    chk("to_forced_route", 32'(cur_route), 32'd1);
    chk_en("to_forced_en", 4'b1001);
    chk("to_evt", 32'(timeout_evt), 32'd1);
    chk("to_in_pkt_clr", 32'(in_pkt), 32'd0);
    chk("to_beat_clr", 32'(beat_cnt), 32'd0);
    chk("to_pkt_hold", 32'(pkt_cnt), 32'd2);
    chk("to_req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("to_evt_pulse", 32'(timeout_evt), 32'd0);
`else
    chk("nto_route_hold", 32'(cur_route), 32'd2);
    chk("nto_evt", 32'(timeout_evt), 32'd0);
    chk("nto_req_ready", 32'(req_ready), 32'd0);
    chk("nto_in_pkt", 32'(in_pkt), 32'd1);
    {s0_tvalid, s0_tready, s0_tlast} = 3'b111;
    tick();
    {s0_tvalid, s0_tready, s0_tlast} = 3'b000;
    chk("nto_route_1", 32'(cur_route), 32'd1);
    chk_en("nto_en_r1", 4'b1001);
    chk("nto_in_pkt_clr", 32'(in_pkt), 32'd0);
    chk("nto_pkt_3", 32'(pkt_cnt), 32'd3);
    chk("nto_req_ready_back", 32'(req_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
